// File: rtl/capture_readout.sv
// capture_readout: streams a circular window of the sample RAM (async read
// port) out as a valid/ready byte stream with a single-beat output register.
// Optional feature macro: CAPTURE_READOUT_CHECKSUM_EN appends one beat that
// carries the XOR of all emitted samples, and moves m_last onto that beat.
module capture_readout #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        CSUM   = 2'd2,
`endif
        STREAM = 2'd1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  fetch;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
`endif

    // RAM is driven straight from the address register: no input->output path
    assign ram_addr = rd_addr;
    assign ram_cs   = (state == STREAM);
    assign ram_oe   = (state == STREAM);

    // Load the output register whenever samples remain and it is empty or draining
    assign fetch = (remaining != '0) && (!m_valid || m_ready);

    // Readout FSM with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        // Only a zero-length request leaves busy set in IDLE
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (start) begin
                        rd_addr   <= start_addr;
                        remaining <= length;
                        busy      <= 1'b1;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                        csum      <= '0;
`endif
                        if (length != '0) state <= STREAM;
                    end
                end
                STREAM: begin
                    if (fetch) begin
                        m_data    <= ram_data;
                        m_valid   <= 1'b1;
                        rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                        csum      <= csum ^ ram_data;
                        m_last    <= 1'b0;
`else
                        m_last    <= (remaining == (ADDR_WIDTH+1)'(1));
`endif
                    end else if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (remaining == '0) begin
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                            // csum already includes the last fetched sample
                            state   <= CSUM;
                            m_data  <= csum;
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
`else
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                CSUM: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: RAM model with async read, stream capture per
// readout, and a queue-based expectation built from the address window.
module tb_capture_readout;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic [7:0] ram_addr;
    logic       ram_cs, ram_oe;
    logic [7:0] ram_data;
    logic [7:0] m_data;
    logic       m_valid, m_ready, m_last, busy, done;

    logic [7:0] mem [256];
    assign ram_data = mem[ram_addr];

    always #5 clk = ~clk;

    capture_readout #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_oe(ram_oe),
        .ram_data(ram_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // expected stream and captured stream
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] cap_data[$];
    bit         cap_last[$];
    logic [7:0] cap_addr[$];
    int first_vld_c, last_hs_edge, done_c, done_cnt, stall_err;
    logic busy0, busy_at_done;

    // Expected beats: samples at sa, sa+1, ... mod 256, optional XOR beat
    task automatic build_exp(input logic [7:0] sa, input int len);
        logic [7:0] x;
        logic [7:0] a;
        x = 8'h00;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < len; i++) begin
            a = sa + 8'(i);
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == len - 1);
            x = x ^ mem[a];
        end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        if (len > 0) begin
            exp_l[len-1] = 1'b0;
            exp_d.push_back(x);
            exp_l.push_back(1'b1);
        end
`endif
    endtask

    // Issue one start and capture the stream. Cycle c is the cycle after edge
    // E(c), E0 being the edge that samples start. m_ready in cycle c (c>=1)
    // follows rpat[c-1] for the first rlen cycles, then stays 1.
    task automatic run(input logic [7:0] sa, input logic [8:0] len,
                       input logic [31:0] rpat, input int rlen, input int inj_c);
        logic [7:0] hold_d;
        logic       hold_l;
        bit         stalled;
        cap_data.delete(); cap_last.delete(); cap_addr.delete();
        first_vld_c = -1; last_hs_edge = -1; done_c = -1; done_cnt = 0;
        stall_err = 0; stalled = 0; busy0 = 1'b0; busy_at_done = 1'bx;
        hold_d = '0; hold_l = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; length = len; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 8'($urandom); length = 9'($urandom);
        for (int c = 0; c < 2000; c++) begin
            if (c == inj_c) begin
                start = 1'b1; start_addr = 8'($urandom); length = 9'd5;
            end else start = 1'b0;
            m_ready = (c >= 1 && c - 1 < rlen) ? rpat[c-1] : 1'b1;
            @(negedge clk);
            if (c == 0) busy0 = busy;
            if (stalled && m_valid && (m_data !== hold_d || m_last !== hold_l)) stall_err++;
            if (ram_cs && (!m_valid || m_ready) && cap_addr.size() < int'(len))
                cap_addr.push_back(ram_addr);
            if (m_valid && first_vld_c < 0) first_vld_c = c;
            if (m_valid && m_ready) begin
                cap_data.push_back(m_data);
                cap_last.push_back(m_last);
                last_hs_edge = c + 1;
            end
            stalled = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (done) begin
                done_cnt++;
                if (done_c < 0) begin done_c = c; busy_at_done = busy; end
            end
            if (done_c >= 0 && c >= done_c + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = 1'($urandom); start_addr = 8'($urandom);
            length = 9'($urandom); m_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({ram_addr, ram_cs, ram_oe, m_data, m_valid, m_last, busy, done} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs got addr=%h cs=%b oe=%b data=%h v=%b l=%b busy=%b done=%b want all 0",
                         ram_addr, ram_cs, ram_oe, m_data, m_valid, m_last, busy, done);
            end
        end
        start = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        build_exp(8'h10, 4);
        run(8'h10, 9'd4, 32'hFFFF_FFFF, 0, -1);
        checks++;
        if (cap_data.size() !== exp_d.size()) begin
            errors++;
            $display("FAIL basic_beats got %0d want %0d", cap_data.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (first_vld_c !== 1) begin
            errors++; $display("FAIL first_valid_cycle got %0d want 1", first_vld_c);
        end
        checks++;
        if (last_hs_edge !== exp_d.size() + 1) begin
            errors++; $display("FAIL last_handshake_edge got %0d want %0d", last_hs_edge, exp_d.size() + 1);
        end
        checks++;
        if (done_c !== last_hs_edge || done_cnt !== 1) begin
            errors++; $display("FAIL done_timing got cyc=%0d cnt=%0d want cyc=%0d cnt=1", done_c, done_cnt, last_hs_edge);
        end
        checks++;
        if (busy0 !== 1'b1 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL busy_window got start=%b at_done=%b want 1/0", busy0, busy_at_done);
        end
    endtask

    task automatic test_wrap;
        build_exp(8'hFE, 4);
        run(8'hFE, 9'd4, 32'hFFFF_FFFF, 0, -1);
        checks++;
        if (cap_addr.size() !== 4) begin
            errors++; $display("FAIL wrap_addr_count got %0d want 4", cap_addr.size());
        end else for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_addr[i] !== 8'(8'hFE + i)) begin
                errors++; $display("FAIL wrap_addr%0d got %h want %h", i, cap_addr[i], 8'(8'hFE + i));
            end
        end
        checks++;
        if (cap_data.size() !== exp_d.size()) begin
            errors++; $display("FAIL wrap_beats got %0d want %0d", cap_data.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                errors++; $display("FAIL wrap_beat%0d got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        build_exp(8'h00, 3);
        run(8'h00, 9'd3, 32'b101001, 6, -1);
        checks++;
        if (cap_data.size() !== exp_d.size()) begin
            errors++; $display("FAIL bp_beats got %0d want %0d", cap_data.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                errors++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (stall_err !== 0) begin
            errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err);
        end
    endtask

    task automatic test_zero_and_busy_start;
        run(8'h33, 9'd0, 32'hFFFF_FFFF, 0, -1);
        checks++;
        if (cap_data.size() !== 0 || first_vld_c !== -1) begin
            errors++; $display("FAIL zero_len_beats got %0d beats want 0", cap_data.size());
        end
        checks++;
        if (done_c !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL zero_len_done got cyc=%0d cnt=%0d want cyc=1 cnt=1", done_c, done_cnt);
        end
        checks++;
        if (busy0 !== 1'b1 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL zero_len_busy got %b/%b want 1/0", busy0, busy_at_done);
        end
        build_exp(8'h20, 8);
        run(8'h20, 9'd8, 32'hFFFF_FFFF, 0, 3);
        checks++;
        if (cap_data.size() !== exp_d.size() || done_cnt !== 1) begin
            errors++; $display("FAIL busy_start_beats got %0d done=%0d want %0d done=1", cap_data.size(), done_cnt, exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                errors++; $display("FAIL busy_start_beat%0d got %h want %h", i, cap_data[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_full_buffer;
        int bad;
        bad = 0;
        build_exp(8'h80, 256);
        run(8'h80, 9'd256, 32'hFFFF_FFFF, 0, -1);
        checks++;
        if (cap_data.size() !== exp_d.size()) begin
            errors++; $display("FAIL full_beats got %0d want %0d", cap_data.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++)
                if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL full_data got %0d bad beats want 0", bad);
            end
        end
        checks++;
        if (last_hs_edge !== exp_d.size() + 1) begin
            errors++; $display("FAIL full_last_edge got %0d want %0d", last_hs_edge, exp_d.size() + 1);
        end
    endtask

    task automatic test_random;
        logic [7:0] sa;
        logic [8:0] len;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 8; t++) begin
            sa  = 8'($urandom);
            len = (t == 0) ? 9'd0 : 9'($urandom_range(1, 40));
            build_exp(sa, int'(len));
            run(sa, len, $urandom, 32, -1);
            checks++;
            if (cap_data.size() !== exp_d.size() || done_cnt !== 1 || stall_err !== 0) begin
                errors++;
                $display("FAIL rand%0d_summary got beats=%0d done=%0d stall=%0d want beats=%0d done=1 stall=0",
                         t, cap_data.size(), done_cnt, stall_err, exp_d.size());
            end else for (int i = 0; i < exp_d.size(); i++) begin
                checks++;
                if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                    errors++; $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", t, i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
                end
            end
        end
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    task automatic test_checksum;
        mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h04;
        build_exp(8'h40, 3);
        run(8'h40, 9'd3, 32'hFFFF_FFFF, 0, -1);
        checks++;
        if (cap_data.size() !== exp_d.size()) begin
            errors++; $display("FAIL csum_beats got %0d want %0d", cap_data.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin
                errors++; $display("FAIL csum_beat%0d got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]);
            end
        end
        for (int i = 8'h40; i <= 8'h42; i++) mem[i] = 8'(i);
    endtask

    task automatic test_abort;
        int saw_done, saw_valid;
        saw_done = 0; saw_valid = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 8'h50; length = 9'd8; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_midstream got v=%b busy=%b want 1/1", m_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_addr, ram_cs, ram_oe, m_data, m_valid, m_last, busy, done} !== 22'd0) begin
            errors++;
            $display("FAIL abort_outputs got addr=%h cs=%b data=%h v=%b busy=%b want all 0",
                     ram_addr, ram_cs, m_data, m_valid, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) saw_done++;
            if (m_valid) saw_valid++;
        end
        checks++;
        if (saw_done !== 0 || saw_valid !== 0) begin
            errors++; $display("FAIL abort_no_done got done=%0d valid=%0d want 0/0", saw_done, saw_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
        test_reset();
        test_wrap();
        test_backpressure();
        test_zero_and_busy_start();
        test_full_buffer();
        test_random();
        test_checksum();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
